fft_radix2_iter: RTL and testbench

//  Parametrised iterative radix-2 DIT FFT/IFFT; successor to the fixed 8-point array-port core.

---
 rtl/fft_radix2_iter.sv | 172 +++++++++++++++++
 tb/tb_fft_radix2_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_iter.sv
// Iterative radix-2 DIT FFT/IFFT: streams N samples in, runs one in-place butterfly
// per cycle over LOG2N stages, then streams the N bins out in natural order.
module fft_radix2_iter #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3,
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int SCALE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inverse,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [DATA_W-1:0] data_in_real,
    input  logic [DATA_W-1:0] data_in_imag,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic [DATA_W-1:0] data_out_real,
    output logic [DATA_W-1:0] data_out_imag,
    output logic              data_out_last,
    output logic              busy,
    output logic              done
);

    localparam int HALF_N = N_POINTS / 2;
    localparam int STG_W  = $clog2(LOG2N + 1);
    localparam int PW     = DATA_W + TW_W;

    localparam logic [STG_W-1:0] LAST_STAGE  = STG_W'(LOG2N - 1);
    localparam logic [LOG2N-2:0] LAST_BFLY   = '1;
    localparam logic [LOG2N-1:0] LAST_SAMPLE = '1;

    localparam logic signed [PW:0]   RND     = {{PW{1'b0}}, 1'b1} << (TW_W - 3);
    localparam logic signed [PW+1:0] SAT_MAX = (PW+2)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PW+1:0] SAT_MIN = (PW+2)'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state_reg, state_next;

    logic [LOG2N-1:0] in_cnt_reg, out_cnt_reg, in_rev;
    logic [LOG2N-2:0] bfly_reg;
    logic [STG_W-1:0] stage_reg;
    logic             inverse_reg, done_reg;
    logic             in_fire, out_fire;

    logic signed [DATA_W-1:0] mem_re [N_POINTS];
    logic signed [DATA_W-1:0] mem_im [N_POINTS];
    logic signed [TW_W-1:0]   tw_re  [HALF_N];
    logic signed [TW_W-1:0]   tw_im  [HALF_N];

    // Forward twiddles exp(-j*2*pi*k/N), rounded to nearest, with 1.0 = 2^(TW_W-2)
    genvar gi;
    generate
        for (gi = 0; gi < HALF_N; gi++) begin : g_tw
            localparam real ANG   = 6.283185307179586 * real'(gi) / real'(N_POINTS);
            localparam real COS_V = $cos(ANG) * (2.0 ** (TW_W - 2));
            localparam real SIN_V = -$sin(ANG) * (2.0 ** (TW_W - 2));
            assign tw_re[gi] = TW_W'($rtoi(COS_V >= 0.0 ? COS_V + 0.5 : COS_V - 0.5));
            assign tw_im[gi] = TW_W'($rtoi(SIN_V >= 0.0 ? SIN_V + 0.5 : SIN_V - 0.5));
        end
        for (gi = 0; gi < LOG2N; gi++) begin : g_rev
            assign in_rev[gi] = in_cnt_reg[LOG2N-1-gi];
        end
    endgenerate

    assign data_in_ready  = !rst && (state_reg == S_IDLE || state_reg == S_LOAD);
    assign data_out_valid = (state_reg == S_UNLOAD);
    assign data_out_last  = data_out_valid && (out_cnt_reg == LAST_SAMPLE);
    assign data_out_real  = data_out_valid ? mem_re[out_cnt_reg] : '0;
    assign data_out_imag  = data_out_valid ? mem_im[out_cnt_reg] : '0;
    assign busy           = (state_reg == S_COMPUTE) || (state_reg == S_UNLOAD);
    assign done           = done_reg;
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = data_out_valid && data_out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (in_fire) state_next = S_LOAD;
            S_LOAD:    if (in_fire && in_cnt_reg == LAST_SAMPLE) state_next = S_COMPUTE;
            S_COMPUTE: if (bfly_reg == LAST_BFLY && stage_reg == LAST_STAGE) state_next = S_UNLOAD;
            S_UNLOAD:  if (out_fire && out_cnt_reg == LAST_SAMPLE) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            bfly_reg    <= '0;
            stage_reg   <= '0;
            inverse_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= out_fire && (out_cnt_reg == LAST_SAMPLE);
            if (in_fire) in_cnt_reg <= in_cnt_reg + 1'b1;
            if (in_fire && state_reg == S_IDLE) inverse_reg <= inverse;
            if (out_fire) out_cnt_reg <= out_cnt_reg + 1'b1;
            if (state_reg == S_COMPUTE) begin
                bfly_reg <= bfly_reg + 1'b1;
                if (bfly_reg == LAST_BFLY)
                    stage_reg <= (stage_reg == LAST_STAGE) ? '0 : stage_reg + 1'b1;
            end
        end
    end

    // Sums are kept wide enough that the rotated operand can never wrap; the final
    // clamp only ever bites in the unscaled build.
    function automatic logic [DATA_W-1:0] sat_dw(input logic signed [PW+1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    logic [LOG2N-1:0]         j_ext, half_mask, top_addr, bot_addr;
    logic [LOG2N-2:0]         tw_idx;
    logic signed [TW_W-1:0]   w_re, w_im;
    logic signed [PW:0]       b_re_x, b_im_x, w_re_x, w_im_x, prod_re, prod_im, rot_re, rot_im;
    logic signed [PW+1:0]     sum_re, sum_im, dif_re, dif_im;
    logic [DATA_W-1:0]        wb_top_re, wb_top_im, wb_bot_re, wb_bot_im;

    always_comb begin
        j_ext     = {1'b0, bfly_reg};
        half_mask = (LOG2N'(1) << stage_reg) - LOG2N'(1);
        top_addr  = ((j_ext >> stage_reg) << (stage_reg + 1'b1)) | (j_ext & half_mask);
        bot_addr  = top_addr | (LOG2N'(1) << stage_reg);
        tw_idx    = (bfly_reg & half_mask[LOG2N-2:0]) << (LOG2N - 1 - int'(stage_reg));
        w_re      = tw_re[tw_idx];
        w_im      = inverse_reg ? -tw_im[tw_idx] : tw_im[tw_idx];
        b_re_x    = (PW+1)'(mem_re[bot_addr]);
        b_im_x    = (PW+1)'(mem_im[bot_addr]);
        w_re_x    = (PW+1)'(w_re);
        w_im_x    = (PW+1)'(w_im);
        prod_re   = b_re_x * w_re_x - b_im_x * w_im_x;
        prod_im   = b_re_x * w_im_x + b_im_x * w_re_x;
        rot_re    = (prod_re + RND) >>> (TW_W - 2);
        rot_im    = (prod_im + RND) >>> (TW_W - 2);
        sum_re    = (PW+2)'(mem_re[top_addr]) + (PW+2)'(rot_re);
        sum_im    = (PW+2)'(mem_im[top_addr]) + (PW+2)'(rot_im);
        dif_re    = (PW+2)'(mem_re[top_addr]) - (PW+2)'(rot_re);
        dif_im    = (PW+2)'(mem_im[top_addr]) - (PW+2)'(rot_im);
        if (SCALE != 0) begin
            sum_re = sum_re >>> 1;
            sum_im = sum_im >>> 1;
            dif_re = dif_re >>> 1;
            dif_im = dif_im >>> 1;
        end
        wb_top_re = sat_dw(sum_re);
        wb_top_im = sat_dw(sum_im);
        wb_bot_re = sat_dw(dif_re);
        wb_bot_im = sat_dw(dif_im);
    end

    // Samples land bit-reversed so the in-place DIT passes leave bins in natural order
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[in_rev] <= data_in_real;
            mem_im[in_rev] <= data_in_imag;
        end
        if (state_reg == S_COMPUTE) begin
            mem_re[top_addr] <= wb_top_re;
            mem_im[top_addr] <= wb_top_im;
            mem_re[bot_addr] <= wb_bot_re;
            mem_im[bot_addr] <= wb_bot_im;
        end
    end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Bench for fft_radix2_iter: directed frames plus random vectors checked against a
// floating-point DFT/N model; a second, unscaled instance covers saturation.
module tb_fft_radix2_iter;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst, inverse, data_in_valid, data_out_ready;
    logic [15:0] data_in_real, data_in_imag;
    logic        data_in_ready, data_out_valid, data_out_last, busy, done;
    logic [15:0] data_out_real, data_out_imag;
    logic        s0_in_ready, s0_out_valid, s0_out_last, s0_busy, s0_done;
    logic [15:0] s0_out_real, s0_out_imag;

    always #5 clk = ~clk;

    fft_radix2_iter #(.N_POINTS(N), .LOG2N(3), .DATA_W(16), .TW_W(16), .SCALE(1)) dut (
        .clk(clk), .rst(rst), .inverse(inverse),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_in_real(data_in_real), .data_in_imag(data_in_imag),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_real(data_out_real), .data_out_imag(data_out_imag),
        .data_out_last(data_out_last), .busy(busy), .done(done)
    );

    fft_radix2_iter #(.N_POINTS(N), .LOG2N(3), .DATA_W(16), .TW_W(16), .SCALE(0)) dut_s0 (
        .clk(clk), .rst(rst), .inverse(inverse),
        .data_in_valid(data_in_valid), .data_in_ready(s0_in_ready),
        .data_in_real(data_in_real), .data_in_imag(data_in_imag),
        .data_out_valid(s0_out_valid), .data_out_ready(data_out_ready),
        .data_out_real(s0_out_real), .data_out_imag(s0_out_imag),
        .data_out_last(s0_out_last), .busy(s0_busy), .done(s0_done)
    );

    int  n_total = 0;
    int  n_pass  = 0;
    int  x_re[N], x_im[N], y_re[N], y_im[N], z_re[N], z_im[N], keep_re[N], keep_im[N];
    real ref_re[N], ref_im[N];

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input real exp, input real tol);
        real d;
        d = real'(obs) - exp;
        n_total++;
        assert (d <= tol && d >= -tol) begin
            n_pass++;
        end else begin
            $display("FAIL %s observed=%0d expected=%0.2f tol=%0.1f", tag, obs, exp, tol);
            $error("check %s", tag);
        end
    endtask

    // Reference: direct DFT of x[] divided by N (e^-j for forward, e^+j for inverse)
    function automatic void dft_model(input bit inv);
        for (int k = 0; k < N; k++) begin
            real sr, si, th, sg;
            sr = 0.0;
            si = 0.0;
            sg = inv ? -1.0 : 1.0;
            for (int n = 0; n < N; n++) begin
                th = 6.283185307179586 * real'(n * k) / real'(N);
                sr += real'(x_re[n]) * $cos(th) + sg * real'(x_im[n]) * $sin(th);
                si += real'(x_im[n]) * $cos(th) - sg * real'(x_re[n]) * $sin(th);
            end
            ref_re[k] = sr / real'(N);
            ref_im[k] = si / real'(N);
        end
    endfunction

    task automatic send_frame(input bit inv, input bit hold);
        int cnt;
        inverse = inv;
        for (int k = 0; k < N; k++) begin
            data_in_valid = 1'b1;
            data_in_real  = 16'(x_re[k]);
            data_in_imag  = 16'(x_im[k]);
            cnt = 0;
            while (!data_in_ready && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 50) begin
                chk("in_ready_timeout", cnt, 0);
                data_in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            inverse = ~inv;
        end
        if (hold) begin
            data_in_real = 16'h5555;
            data_in_imag = 16'h2AAA;
        end else begin
            data_in_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(input bit bp, input real tol);
        int cnt;
        cnt = 0;
        chk("busy_compute", int'(busy), 1);
        while (!data_out_valid && cnt < 200) begin
            if (cnt == 1) chk("in_ready_compute", int'(data_in_ready), 0);
            @(negedge clk);
            cnt++;
        end
        chk("compute_len", cnt, 12);
        data_in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            forever begin
                if (!data_out_valid || cnt > 50) begin
                    chk("out_valid_timeout", int'(data_out_valid), 1);
                    data_out_ready = 1'b0;
                    return;
                end
                data_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                chk_tol("bin_re", int'($signed(data_out_real)), ref_re[k], tol);
                chk_tol("bin_im", int'($signed(data_out_imag)), ref_im[k], tol);
                if (data_out_ready) break;
                @(negedge clk);
                cnt++;
            end
            chk("last_flag", int'(data_out_last), (k == N - 1) ? 1 : 0);
            y_re[k] = int'($signed(data_out_real));
            y_im[k] = int'($signed(data_out_imag));
            z_re[k] = int'($signed(s0_out_real));
            z_im[k] = int'($signed(s0_out_imag));
            $display("out bin=%0d re=%0d im=%0d last=%0b unscaled_re=%0d", k, y_re[k], y_im[k],
                     data_out_last, z_re[k]);
            @(negedge clk);
        end
        data_out_ready = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("ready_at_done", int'(data_in_ready), 1);
        chk("valid_after_last", int'(data_out_valid), 0);
        @(negedge clk);
        chk("done_single", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inverse = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        data_in_real = '0; data_in_imag = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(data_in_ready), 0);
        chk("rst_out_valid", int'(data_out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_real", int'(data_out_real), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(data_in_ready), 1);

        // Impulse: every bin exactly 0x0800 + j0
        for (int n = 0; n < N; n++) begin x_re[n] = (n == 0) ? 16384 : 0; x_im[n] = 0; end
        dft_model(1'b0);
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, 0.0);

        // DC 0x1000
        for (int n = 0; n < N; n++) begin x_re[n] = 4096; x_im[n] = 0; end
        dft_model(1'b0);
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, 1.0);

        // Cosine at bin 1
        for (int n = 0; n < N; n++) begin
            x_re[n] = int'(16384.0 * $cos(6.283185307179586 * real'(n) / real'(N)));
            x_im[n] = 0;
        end
        dft_model(1'b0);
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, 2.0);

        // Round trip: random forward, then inverse of the result -> input/N
        for (int n = 0; n < N; n++) begin
            x_re[n] = int'($urandom_range(32766)) - 16383;
            x_im[n] = int'($urandom_range(32766)) - 16383;
            keep_re[n] = x_re[n];
            keep_im[n] = x_im[n];
        end
        dft_model(1'b0);
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, 3.0);
        for (int n = 0; n < N; n++) begin
            x_re[n] = y_re[n];
            x_im[n] = y_im[n];
            ref_re[n] = real'(keep_re[n]) / real'(N);
            ref_im[n] = real'(keep_im[n]) / real'(N);
        end
        send_frame(1'b1, 1'b0);
        recv_frame(1'b0, 4.0);

        // Backpressure with input valid held high through COMPUTE
        for (int n = 0; n < N; n++) begin
            x_re[n] = int'($urandom_range(32766)) - 16383;
            x_im[n] = int'($urandom_range(32766)) - 16383;
        end
        dft_model(1'b0);
        send_frame(1'b0, 1'b1);
        recv_frame(1'b1, 3.0);

        // Reset in the middle of COMPUTE, with input valid asserted during reset
        send_frame(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        data_in_valid = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(data_out_valid), 0);
        chk("midrst_in_ready", int'(data_in_ready), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_out_imag", int'(data_out_imag), 0);
        chk("midrst_s0_busy", int'(s0_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        data_in_valid = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", int'(data_in_ready), 1);

        // Full-scale DC: scaled core keeps 0x7FFF, unscaled core saturates bin 0
        for (int n = 0; n < N; n++) begin x_re[n] = 32767; x_im[n] = 0; end
        dft_model(1'b0);
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0, 1.0);
        for (int k = 0; k < N; k++) begin
            chk("sat_re", z_re[k], (k == 0) ? 32767 : 0);
            chk("sat_im", z_im[k], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
